measurement_round_framer: RTL and testbench
===========================================

# measurement_round_framer

Upstream feeder of the single-FPGA decoder's 32-bit `input_data/input_valid/input_ready` port. It accepts one measurement round at a time (`GRID_WIDTH_X*GRID_WIDTH_Z` syndrome bits) from the readout front-end and serialises each decode into a frame of 32-bit words: header, round payload words, and trailer. The trailer carries a round-count check and an optional defect popcount, so the controller sees a fixed, self-checking stream.

## Interface
- `GRID_WIDTH_X`, 12: PUs per row.
- `GRID_WIDTH_Z`, 2: rows per round.
- `GRID_WIDTH_U`, 10: expected rounds per decode.
- `NUM_CONTEXTS`, 2: decoder contexts. Context id width is `CTX_W = max(1, $clog2(NUM_CONTEXTS))`.
- Derived: `PU_COUNT_PER_ROUND = GRID_WIDTH_X*GRID_WIDTH_Z`; `WORDS_PER_ROUND = ceil(PU_COUNT_PER_ROUND/32)`.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `round_data`  in  PU_COUNT_PER_ROUND  syndrome bits of one round; bit 0 is PU (0,0).
- `round_last`  in  1  marks the final round of the decode.
- `round_context`  in  CTX_W  context id; sampled on the first round of a frame only.
- `round_valid` / `round_ready`  in/out  1  round handshake.
- `out_data`  out  32  frame word to the decoder `input_data`.
- `out_valid` / `out_ready`  out/in  1  word handshake.
- `frame_seq`  out  16  count of completed frames.
- `round_mismatch`  out  1  sticky flag: a frame ended with rounds ≠ `GRID_WIDTH_U`.

## Operation
- FSM states: IDLE, HEADER, DATA, WAIT, TRAILER.
- IDLE:
  - `round_ready=1`.
  - On `round_valid`: capture `round_data`, `round_last` and `round_context`; set rounds=1; go to HEADER.
- HEADER:
  - `out_data = {8'hA5, 8'(context), frame_seq}`.
  - On accept: word_idx=0; go to DATA.
- DATA:
  - `out_data` = captured round bits `[32*word_idx +: 32]`. Bits above `PU_COUNT_PER_ROUND` are zero.
  - Each accept increments word_idx.
  - On accept of word `WORDS_PER_ROUND-1`: go to TRAILER if the captured last flag is set, else go to WAIT.
- WAIT:
  - `round_ready=1`.
  - On `round_valid`: capture the round; rounds++ (saturating at 255); word_idx=0; go to DATA.
  - `round_context` is ignored in WAIT.
- TRAILER:
  - `out_data = {8'h5A, rounds[7:0], mismatch, popcount[14:0]}`, where mismatch = (rounds != `GRID_WIDTH_U`).
  - On accept: frame_seq++ (wraps 16'hFFFF→0); `round_mismatch |= mismatch`; go to IDLE.
- Popcount: 15-bit accumulation of set bits over all rounds of the frame, saturating at 0x7FFF. It is cleared on frame start.
- `round_ready` is 0 in HEADER, DATA and TRAILER, so there is no skid path.
- Async reset (including mid-frame):
  - State → IDLE; `out_valid=0`; `out_data=0`.
  - `frame_seq=0`; `round_mismatch=0`; counters cleared.
  - A partial frame is discarded, with no trailer.

## Timing
- `out_valid` is high exactly in HEADER, DATA and TRAILER.
- `out_data` is registered and stable while `out_valid && !out_ready`.
- Latency: round accepted at edge N → header valid from cycle N+1.
- With `out_ready` held at 1, a frame takes `1 + R*WORDS_PER_ROUND + 1` output cycles, plus one WAIT cycle per round boundary while `round_valid` is held high.
- Simultaneous `round_valid` and a final-word accept: the round is not taken until WAIT, one cycle later.
- `frame_seq` and `round_mismatch` update on the edge that accepts the trailer.

## Configuration
- `MEAS_FRAMER_POPCOUNT_EN`:
  - Defined: popcount is accumulated and placed in trailer bits `[14:0]`.
  - Undefined: trailer bits `[14:0]` are 0 and no popcount logic is built.

## Structure
- Shared package `helios_framer_pkg`:
  - Sync constants `FRAME_HDR_SYNC=8'hA5` and `FRAME_TRL_SYNC=8'h5A`.
  - State enum.
  - `words_per_round()` function.
- Sub-module `round_popcount`: combinational adder tree over `PU_COUNT_PER_ROUND` bits. It is instantiated only under the macro.

## Test plan
- Defaults, 10 rounds of `24'h000001`, last on round 10, `out_ready=1` → words A5000000, ten × 00000001, then 5A0A000A; `frame_seq`=1; `round_mismatch`=0.
- 3 rounds with last on round 3, context 1 → header A5010000, trailer 5A038000 | popcount; `round_mismatch`=1.
- `out_ready` toggled 1/0 every cycle through a full frame → no word dropped or duplicated; `out_data` stable while stalled.
- Reset asserted while in DATA of round 4 → `out_valid`=0 the same cycle; the next frame header is A5000000.
- Macro undefined, all-ones rounds → trailer low 15 bits = 0. Macro defined, 10 rounds of `24'hFFFFFF` → popcount 240 (trailer 5A0A00F0).
- `GRID_WIDTH_X=20`, `Z=2` (40 bits, 2 words/round) → second payload word carries bits [39:32] with upper 24 bits zero.

Source files
------------

// File: rtl/helios_framer_pkg.sv
// ----------------------------------------------------------------------------
// helios_framer_pkg
// Shared definitions for the measurement-round framer:
//   FRAME_HDR_SYNC / FRAME_TRL_SYNC : sync bytes opening header / trailer words
//   framer_state_e                  : framer FSM state encoding
//   words_per_round()               : 32-bit payload words per round
// ----------------------------------------------------------------------------
package helios_framer_pkg;

   localparam logic [7:0] FRAME_HDR_SYNC = 8'hA5;
   localparam logic [7:0] FRAME_TRL_SYNC = 8'h5A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_DATA,
      ST_WAIT,
      ST_TRAILER
   } framer_state_e;

   function automatic int words_per_round(input int pu_count);
      return (pu_count + 31) / 32;
   endfunction

endpackage

// File: rtl/round_popcount.sv
// ----------------------------------------------------------------------------
// round_popcount
// Combinational count of set bits in one round of syndrome data.
// Ports:
//   bits  in  N_BITS  syndrome bits of one round
//   count out CNT_W   number of bits set in `bits`
// ----------------------------------------------------------------------------
module round_popcount #(
   parameter int N_BITS = 24,
   parameter int CNT_W  = $clog2(N_BITS + 1)
) (
   input  logic [N_BITS-1:0] bits,
   output logic [CNT_W-1:0]  count
);

   // Written as a linear sum; synthesis rebalances it into an adder tree.
   always_comb begin
      count = '0;
      for (int i = 0; i < N_BITS; i++) begin
         count = count + CNT_W'(bits[i]);
      end
   end

endmodule

// File: rtl/measurement_round_framer.sv
// ----------------------------------------------------------------------------
// measurement_round_framer
// Accepts measurement rounds from the readout front-end and serialises each
// decode into a frame of 32-bit words: header, payload words of every round,
// trailer with round count, round-count mismatch bit and optional popcount.
//
// Optional feature macro: MEAS_FRAMER_POPCOUNT_EN
//   defined   : defect popcount accumulated into trailer bits [14:0]
//   undefined : trailer bits [14:0] are zero, no popcount logic built
//
// Ports:
//   clk            in   1      clock
//   reset          in   1      asynchronous active-low reset
//   round_data     in   PU     syndrome bits of one round (bit 0 = PU (0,0))
//   round_last     in   1      final round of the decode
//   round_context  in   CTX_W  context id, sampled on the first round only
//   round_valid    in   1      round handshake valid
//   round_ready    out  1      round handshake ready (IDLE / WAIT only)
//   out_data       out  32     frame word towards decoder input_data
//   out_valid      out  1      word handshake valid
//   out_ready      in   1      word handshake ready
//   frame_seq      out  16     count of completed frames
//   round_mismatch out  1      sticky: a frame ended with rounds != GRID_WIDTH_U
// ----------------------------------------------------------------------------
module measurement_round_framer
   import helios_framer_pkg::*;
#(
   parameter int GRID_WIDTH_X = 12,
   parameter int GRID_WIDTH_Z = 2,
   parameter int GRID_WIDTH_U = 10,
   parameter int NUM_CONTEXTS = 2,
   localparam int CTX_W = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1,
   localparam int PU_COUNT_PER_ROUND = GRID_WIDTH_X * GRID_WIDTH_Z
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [PU_COUNT_PER_ROUND-1:0] round_data,
   input  logic                          round_last,
   input  logic [CTX_W-1:0]              round_context,
   input  logic                          round_valid,
   output logic                          round_ready,
   output logic [31:0]                   out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [15:0]                   frame_seq,
   output logic                          round_mismatch
);

   localparam int WORDS_PER_ROUND = words_per_round(PU_COUNT_PER_ROUND);
   localparam int PAD_W = WORDS_PER_ROUND * 32;
   localparam int IDX_W = (WORDS_PER_ROUND > 1) ? $clog2(WORDS_PER_ROUND) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_ROUND - 1);

   framer_state_e    state;
   logic [PAD_W-1:0] cap_bits;
   logic             cap_last;
   logic [7:0]       rounds;
   logic [IDX_W-1:0] word_idx;
   logic [14:0]      trl_pop;
   logic             round_count_bad;
   logic             round_accept;
   logic             out_accept;

   assign round_ready     = (state == ST_IDLE) || (state == ST_WAIT);
   assign round_accept    = round_valid && round_ready;
   assign out_accept      = out_valid && out_ready;
   assign round_count_bad = (32'(rounds) != 32'(GRID_WIDTH_U));

   function automatic logic [31:0] word_sel(input logic [PAD_W-1:0] v, input int idx);
      return v[idx*32 +: 32];
   endfunction

   function automatic logic [7:0] sat_inc_rounds(input logic [7:0] r);
      return (r == 8'hFF) ? r : r + 8'd1;
   endfunction

`ifdef MEAS_FRAMER_POPCOUNT_EN
   localparam int PC_W = $clog2(PU_COUNT_PER_ROUND + 1);

   logic [PC_W-1:0] round_pc;
   logic [14:0]     popcnt;

   round_popcount #(
      .N_BITS (PU_COUNT_PER_ROUND),
      .CNT_W  (PC_W)
   ) u_round_popcount (
      .bits  (round_data),
      .count (round_pc)
   );

   function automatic logic [14:0] sat_add_pop(input logic [14:0] acc, input logic [PC_W-1:0] inc);
      logic [31:0] s;
      s = 32'(acc) + 32'(inc);
      return (s > 32'h7FFF) ? 15'h7FFF : s[14:0];
   endfunction

   assign trl_pop = popcnt;
`else
   assign trl_pop = '0;
`endif

   // Payload storage carries no control meaning, so it is left unreset;
   // it is always rewritten before the FSM reads it.
   always_ff @(posedge clk) begin
      if (round_accept) begin
         cap_bits <= PAD_W'(round_data);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= ST_IDLE;
         out_valid      <= 1'b0;
         out_data       <= '0;
         frame_seq      <= '0;
         round_mismatch <= 1'b0;
         rounds         <= '0;
         word_idx       <= '0;
         cap_last       <= 1'b0;
`ifdef MEAS_FRAMER_POPCOUNT_EN
         popcnt         <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (round_accept) begin
                  cap_last  <= round_last;
                  rounds    <= 8'd1;
                  word_idx  <= '0;
                  out_data  <= {FRAME_HDR_SYNC, 8'(round_context), frame_seq};
                  out_valid <= 1'b1;
                  state     <= ST_HEADER;
`ifdef MEAS_FRAMER_POPCOUNT_EN
                  popcnt    <= sat_add_pop(15'd0, round_pc);
`endif
               end
            end

            ST_HEADER: begin
               if (out_accept) begin
                  out_data <= word_sel(cap_bits, 0);
                  word_idx <= '0;
                  state    <= ST_DATA;
               end
            end

            ST_DATA: begin
               if (out_accept) begin
                  if (word_idx == LAST_IDX) begin
                     if (cap_last) begin
                        // rounds and popcount are final here: the last round
                        // was folded in when it was captured.
                        out_data <= {FRAME_TRL_SYNC, rounds, round_count_bad, trl_pop};
                        state    <= ST_TRAILER;
                     end else begin
                        out_data  <= '0;
                        out_valid <= 1'b0;
                        state     <= ST_WAIT;
                     end
                  end else begin
                     word_idx <= word_idx + IDX_W'(1);
                     out_data <= word_sel(cap_bits, int'(word_idx) + 1);
                  end
               end
            end

            ST_WAIT: begin
               // round_context is deliberately ignored past the first round
               if (round_accept) begin
                  cap_last  <= round_last;
                  rounds    <= sat_inc_rounds(rounds);
                  word_idx  <= '0;
                  out_data  <= word_sel(PAD_W'(round_data), 0);
                  out_valid <= 1'b1;
                  state     <= ST_DATA;
`ifdef MEAS_FRAMER_POPCOUNT_EN
                  popcnt    <= sat_add_pop(popcnt, round_pc);
`endif
               end
            end

            ST_TRAILER: begin
               if (out_accept) begin
                  frame_seq      <= frame_seq + 16'd1;
                  round_mismatch <= round_mismatch | round_count_bad;
                  out_valid      <= 1'b0;
                  out_data       <= '0;
                  state          <= ST_IDLE;
               end
            end

            default: begin
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_measurement_round_framer.sv
// ----------------------------------------------------------------------------
// tb_measurement_round_framer
// Bench for measurement_round_framer: default 24-bit geometry driven from a
// table of frames with a word scoreboard, plus a 40-bit (two words per round)
// instance exercised by a hand-written sequence.
// ----------------------------------------------------------------------------
module tb_measurement_round_framer;

`ifdef MEAS_FRAMER_POPCOUNT_EN
   localparam bit POP_EN = 1'b1;
`else
   localparam bit POP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;

   // default instance: 12 x 2 = 24 bits per round
   logic [23:0] round_data;
   logic        round_last;
   logic [0:0]  round_context;
   logic        round_valid;
   logic        round_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] frame_seq;
   logic        round_mismatch;

   // wide instance: 20 x 2 = 40 bits per round
   logic [39:0] rd40;
   logic        rl40;
   logic [0:0]  rc40;
   logic        rv40;
   logic        rr40;
   logic [31:0] od40;
   logic        ov40;
   logic        ork40;
   logic [15:0] fs40;
   logic        rm40;

   always #5 clk = ~clk;

   measurement_round_framer u_dut (
      .clk            (clk),
      .reset          (reset),
      .round_data     (round_data),
      .round_last     (round_last),
      .round_context  (round_context),
      .round_valid    (round_valid),
      .round_ready    (round_ready),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .frame_seq      (frame_seq),
      .round_mismatch (round_mismatch)
   );

   measurement_round_framer #(
      .GRID_WIDTH_X (20),
      .GRID_WIDTH_Z (2)
   ) u_dut40 (
      .clk            (clk),
      .reset          (reset),
      .round_data     (rd40),
      .round_last     (rl40),
      .round_context  (rc40),
      .round_valid    (rv40),
      .round_ready    (rr40),
      .out_data       (od40),
      .out_valid      (ov40),
      .out_ready      (ork40),
      .frame_seq      (fs40),
      .round_mismatch (rm40)
   );

   typedef struct {
      int          nrounds;
      logic        ctx;
      logic [23:0] pat;
      bit          vary;      // xor round index into bits [23:16]
      bit          toggle;    // out_ready alternates 0/1
      int          abort_round;
      logic [31:0] exp_hdr;
      logic [31:0] exp_trl;   // trailer without popcount field
   } vec_t;

   typedef struct {
      logic [31:0] data;
      bit          is_trl;
   } exp_t;

   vec_t        vecs[7];
   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] seq_m = '0;
   logic        mm_m  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: bound expired", name);
   endtask

   task automatic run_frame(input int fi, input vec_t v);
      int          taken   = 0;
      int          cyc     = 0;
      int          pop     = 0;
      bit          done    = 0;
      bit          aborted = 0;
      bit          stall_prev = 0;
      bit          hdr_due = 0;
      bit          tog_ph  = 0;
      logic [31:0] od_prev = '0;
      logic [23:0] d;
      exp_t        e;
      while (!done) begin
         @(negedge clk);
         cyc++;
         if (cyc > 600) begin
            fail_now($sformatf("frame%0d_timeout", fi));
            break;
         end
         if (stall_prev) begin
            chk($sformatf("frame%0d_stall_valid", fi), 32'(out_valid), 32'd1);
            chk($sformatf("frame%0d_stall_data", fi), out_data, od_prev);
         end
         if (hdr_due) begin
            chk($sformatf("frame%0d_hdr_latency", fi), 32'(out_valid), 32'd1);
            hdr_due = 0;
         end
         if (v.abort_round > 0 && taken == v.abort_round && out_valid) begin
            reset = 1'b0;
            #1;
            chk("abort_out_valid", 32'(out_valid), 32'd0);
            chk("abort_out_data", out_data, 32'd0);
            chk("abort_frame_seq", 32'(frame_seq), 32'd0);
            chk("abort_mismatch", 32'(round_mismatch), 32'd0);
            round_valid = 1'b0;
            out_ready   = 1'b0;
            exp_q.delete();
            seq_m = '0;
            mm_m  = 1'b0;
            @(negedge clk);
            reset   = 1'b1;
            aborted = 1;
            break;
         end
         out_ready = v.toggle ? tog_ph : 1'b1;
         tog_ph    = !tog_ph;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL frame%0d_extra_word: got %h required none", fi, out_data);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("frame%0d_word", fi), out_data, e.data);
               if (e.is_trl) done = 1;
            end
         end
         stall_prev = out_valid && !out_ready;
         od_prev    = out_data;
         if (taken < v.nrounds) begin
            d = v.vary ? (v.pat ^ {8'(taken), 16'h0}) : v.pat;
            round_valid   = 1'b1;
            round_data    = d;
            round_last    = (taken == v.nrounds - 1);
            round_context = (taken == 0) ? v.ctx : ~v.ctx;
            if (round_ready) begin
               if (taken == 0) begin
                  exp_q.push_back('{v.exp_hdr, 1'b0});
                  hdr_due = 1;
               end
               exp_q.push_back('{32'(d), 1'b0});
               pop = pop + $countones(d);
               if (pop > 32'h7FFF) pop = 32'h7FFF;
               if (taken == v.nrounds - 1)
                  exp_q.push_back('{v.exp_trl | (POP_EN ? 32'(pop) : 32'd0), 1'b1});
               taken++;
            end
         end else begin
            round_valid = 1'b0;
         end
      end
      round_valid = 1'b0;
      if (!aborted && done) begin
         @(negedge clk);   // trailer accepted on the edge just passed
         out_ready = 1'b0;
         seq_m = seq_m + 16'd1;
         mm_m  = mm_m | (v.nrounds != 10);
         chk($sformatf("frame%0d_frame_seq", fi), 32'(frame_seq), 32'(seq_m));
         chk($sformatf("frame%0d_mismatch", fi), 32'(round_mismatch), 32'(mm_m));
         chk($sformatf("frame%0d_queue_left", fi), exp_q.size(), 32'd0);
         chk($sformatf("frame%0d_idle_valid", fi), 32'(out_valid), 32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [31:0] exp40[4];
      logic [39:0] w40;
      int          got;
      int          cyc;

      vecs[0] = '{10, 1'b0, 24'h000001, 1'b0, 1'b0, 0, 32'hA5000000, 32'h5A0A0000};
      vecs[1] = '{ 3, 1'b1, 24'h000001, 1'b0, 1'b0, 0, 32'hA5010001, 32'h5A038000};
      vecs[2] = '{10, 1'b0, 24'hFFFFFF, 1'b0, 1'b1, 0, 32'hA5000002, 32'h5A0A0000};
      vecs[3] = '{ 4, 1'b1, 24'h123456, 1'b1, 1'b1, 0, 32'hA5010003, 32'h5A048000};
      vecs[4] = '{10, 1'b0, 24'h000001, 1'b0, 1'b0, 4, 32'hA5000004, 32'h5A0A0000};
      vecs[5] = '{10, 1'b0, 24'h000001, 1'b0, 1'b0, 0, 32'hA5000000, 32'h5A0A0000};
      vecs[6] = '{ 1, 1'b1, 24'hA5A5A5, 1'b0, 1'b1, 0, 32'hA5010001, 32'h5A018000};

      reset         = 1'b0;
      round_data    = '0;
      round_last    = 1'b0;
      round_context = '0;
      round_valid   = 1'b0;
      out_ready     = 1'b0;
      rd40  = '0;
      rl40  = 1'b0;
      rc40  = '0;
      rv40  = 1'b0;
      ork40 = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_frame_seq", 32'(frame_seq), 32'd0);
      chk("rst_mismatch", 32'(round_mismatch), 32'd0);
      chk("rst_round_ready", 32'(round_ready), 32'd1);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_frame(i, vecs[i]);
      end

      // two payload words per round: upper word holds bits [39:32]
      w40 = 40'hAB_1234_5678;
      exp40[0] = 32'hA5000000;
      exp40[1] = 32'h12345678;
      exp40[2] = 32'h000000AB;
      exp40[3] = 32'h5A018000 | (POP_EN ? 32'($countones(w40)) : 32'd0);
      @(negedge clk);
      chk("w40_ready", 32'(rr40), 32'd1);
      rd40  = w40;
      rl40  = 1'b1;
      rv40  = 1'b1;
      ork40 = 1'b1;
      @(negedge clk);
      rv40 = 1'b0;
      got  = 0;
      cyc  = 0;
      while (got < 4 && cyc < 50) begin
         if (ov40) begin
            chk($sformatf("w40_word%0d", got), od40, exp40[got]);
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      if (got < 4) fail_now("w40_timeout");
      chk("w40_frame_seq", 32'(fs40), 32'd1);
      chk("w40_mismatch", 32'(rm40), 32'd1);
      chk("w40_idle_valid", 32'(ov40), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
